// File: rtl/hwgen_ifg_scheduler.sv
// hwgen_ifg_scheduler: paces replayed hwgen packets onto the transmit AXI4-Stream,
// holding each packet until its inter-frame gap has elapsed. Optional macro: HWGEN_SCHED_LEN_CHECK_EN.
module hwgen_ifg_scheduler #(
    parameter int DATA_WIDTH   = 64,
    parameter int NS2CYC_MUL   = 5,
    parameter int NS2CYC_SHIFT = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sched_en,
    input  logic                    hdr_valid,
    output logic                    hdr_ready,
    input  logic [15:0]             hdr_magic,
    input  logic [15:0]             hdr_orig_len,
    input  logic [31:0]             hdr_ifg,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_tstrb,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [31:0]             pkt_cnt,
    output logic [31:0]             drop_cnt,
    output logic [31:0]             len_err_cnt
);

    localparam int          STRB_W = DATA_WIDTH / 8;
    localparam logic [15:0] MAGIC  = 16'h6969;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SEND,
        ST_DROP
    } state_t;

    state_t      state_q, state_d;
    logic        ready_en_q, ready_en_d;
    logic [31:0] ifg_cyc_q, ifg_cyc_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    logic hdr_hs;
    logic s_hs;
    logic m_hs;
    logic m_last_hs;

    // Ceiling of ns * MUL / 2^SHIFT; 35 bits keeps the product exact for any 32-bit gap.
    function automatic logic [31:0] ns_to_cyc(input logic [31:0] ns);
        logic [34:0] scaled;
        scaled = 35'(ns) * 35'(NS2CYC_MUL) + ((35'(1) << NS2CYC_SHIFT) - 35'(1));
        return 32'(scaled >> NS2CYC_SHIFT);
    endfunction

    always_comb begin
        hdr_ready = 1'b0;
        s_tready  = 1'b0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tstrb   = '0;
        m_tdata   = '0;
        case (state_q)
            ST_IDLE: hdr_ready = sched_en && ready_en_q;
            ST_SEND: begin
                m_tvalid = s_tvalid;
                s_tready = m_tready;
                m_tlast  = s_tlast;
                m_tstrb  = s_tstrb;
                m_tdata  = s_tdata;
            end
            ST_DROP: s_tready = 1'b1;
            default: ;
        endcase
    end

    assign hdr_hs    = hdr_valid && hdr_ready;
    assign s_hs      = s_tvalid && s_tready;
    assign m_hs      = m_tvalid && m_tready;
    assign m_last_hs = m_hs && m_tlast;

    always_comb begin
        state_d    = state_q;
        ifg_cyc_d  = ifg_cyc_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ready_en_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (hdr_hs) begin
                    ifg_cyc_d = ns_to_cyc(hdr_ifg);
                    state_d   = (hdr_magic == MAGIC) ? ST_GAP : ST_DROP;
                end
            end
            ST_GAP: begin
                if (idle_cnt_q >= ifg_cyc_q) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_last_hs) begin
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (s_hs && s_tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gap is measured from the last tlast handshake; a clear in the same cycle beats the increment.
    always_comb begin
        if (m_last_hs) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            ifg_cyc_q  <= '0;
            idle_cnt_q <= '1;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            ifg_cyc_q  <= ifg_cyc_d;
            idle_cnt_q <= idle_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

`ifdef HWGEN_SCHED_LEN_CHECK_EN
    logic [15:0] orig_len_q, orig_len_d;
    logic [15:0] byte_acc_q, byte_acc_d;
    logic [15:0] byte_sum;
    logic [31:0] len_err_cnt_q, len_err_cnt_d;

    function automatic logic [15:0] popcount(input logic [STRB_W-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) begin
            n = n + 16'(v[i]);
        end
        return n;
    endfunction

    assign byte_sum = byte_acc_q + popcount(s_tstrb);

    // Holding the accumulator at zero through GAP clears it on entry to SEND.
    always_comb begin
        orig_len_d    = orig_len_q;
        byte_acc_d    = byte_acc_q;
        len_err_cnt_d = len_err_cnt_q;
        if (hdr_hs) begin
            orig_len_d = hdr_orig_len;
        end
        if (state_q == ST_GAP) begin
            byte_acc_d = '0;
        end else if (state_q == ST_SEND && m_hs) begin
            byte_acc_d = byte_sum;
            if (m_tlast && byte_sum != orig_len_q) begin
                len_err_cnt_d = len_err_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig_len_q    <= '0;
            byte_acc_q    <= '0;
            len_err_cnt_q <= '0;
        end else begin
            orig_len_q    <= orig_len_d;
            byte_acc_q    <= byte_acc_d;
            len_err_cnt_q <= len_err_cnt_d;
        end
    end

    assign len_err_cnt = len_err_cnt_q;
`else
    logic unused_orig_len;

    assign unused_orig_len = ^hdr_orig_len;
    assign len_err_cnt     = '0;
`endif

endmodule

// File: doc/hwgen_ifg_scheduler.md
# hwgen_ifg_scheduler

Paces replayed packets onto the transmit AXI4-Stream according to the hwgen per-packet header (magic 16'h6969, orig_len, ifg in ns). It accepts one parsed header per packet, enforces the inter-frame gap measured from the previous packet's last beat, and then releases that packet's payload beats. Packets with a bad magic are dropped. It sits between the pcap-to-hwgen header parser and the MAC-side AXI4-Stream output, and runs at the 156.25 MHz core clock.

## Interface
Parameters:
- DATA_WIDTH, 64, tdata width in bits; tstrb is DATA_WIDTH/8.
- NS2CYC_MUL, 5, numerator of the ns→cycle factor (6.4 ns/cycle = 32/5).
- NS2CYC_SHIFT, 5, log2 of the ns→cycle denominator.

Ports:
- clk  in  1  core clock, one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- sched_en  in  1  when low, no new header is accepted; a packet already in progress completes.
- hdr_valid / hdr_ready  in / out  1 / 1  header handshake.
- hdr_magic  in  16  header magic.
- hdr_orig_len  in  16  packet length in bytes.
- hdr_ifg  in  32  gap in ns before this packet.
- s_tvalid, s_tready, s_tlast  in, out, in  1 each  payload stream input.
- s_tstrb, s_tdata  in  DATA_WIDTH/8, DATA_WIDTH  payload stream input.
- m_tvalid, m_tready, m_tlast  out, in, out  1 each  paced stream output.
- m_tstrb, m_tdata  out  DATA_WIDTH/8, DATA_WIDTH  paced stream output.
- pkt_cnt  out  32  count of packets sent (tlast handshakes on m).
- drop_cnt  out  32  count of packets dropped for bad magic.
- len_err_cnt  out  32  count of sent packets whose byte count ≠ orig_len.

## Operation
**Gap arithmetic**
- ifg_cyc = (hdr_ifg·NS2CYC_MUL + 2^NS2CYC_SHIFT − 1) >> NS2CYC_SHIFT. This is the ceiling of the gap in cycles.
- Compute in 35 bits. Register the 32-bit result when the header is accepted.

**idle_cnt (32-bit)**
- Cleared to 0 in the cycle of an m tlast handshake.
- Otherwise increments every cycle and saturates at 2^32−1.
- Reset value is 2^32−1, so the first packet after reset is not delayed.

**State machine** (states IDLE, GAP, SEND, DROP; reset state IDLE)
- IDLE: hdr_ready = sched_en.
  - On a header handshake: magic = 16'h6969 → GAP; any other magic → DROP.
- GAP: s_tready = 0, m_tvalid = 0.
  - When idle_cnt ≥ ifg_cyc → SEND.
- SEND: combinational passthrough.
  - m_tvalid = s_tvalid and s_tready = m_tready; m_tdata, m_tstrb and m_tlast follow s_*.
  - On an m tlast handshake: pkt_cnt += 1, then → IDLE.
- DROP: s_tready = 1, m_tvalid = 0.
  - Each beat is consumed and discarded.
  - On an s tlast handshake: drop_cnt += 1, then → IDLE.
- In IDLE, GAP and DROP, no s beat is forwarded to m.
- Counters wrap modulo 2^32.
- Changes in sched_en take effect only in IDLE.

## Timing
**Reset values**
- hdr_ready = 0, s_tready = 0, m_tvalid = 0, m_tlast = 0.
- m_tdata and m_tstrb are 0 while not in SEND.
- All counters are 0.
- hdr_ready is first asserted in the cycle after rst_n deasserts, provided sched_en = 1.

**Latency and pacing**
- Header handshake in IDLE at cycle h → GAP at h+1. The earliest SEND is h+2.
- In SEND the data path has zero latency (combinational).
- Previous tlast handshake at cycle t: the earliest next first beat on m is at cycle t + max(3, ifg_cyc + 2).

**Boundary conditions**
- ifg = 0: the minimum spacing is 2 dead cycles.
- ifg near 2^32: the 35-bit product must not overflow.
- The header arrives long after tlast: idle_cnt already exceeds ifg_cyc, so the packet is sent at h+2.
- m_tready low in SEND: stall. idle_cnt keeps counting but is irrelevant while in SEND.
- A tlast handshake and an idle_cnt increment in the same cycle: the clear wins.
- A single-beat packet (tlast on the first beat) is valid in both SEND and DROP.
- rst_n asserted mid-packet: all outputs return to reset values immediately. No tlast is emitted, so the truncated packet is abandoned.

## Configuration
Macro: HWGEN_SCHED_LEN_CHECK_EN.

**Defined**
- A 16-bit byte accumulator adds popcount(s_tstrb) on each SEND beat handshake.
- At the tlast handshake, if the total (including that beat) ≠ hdr_orig_len, len_err_cnt += 1.
- The accumulator clears on entry to SEND.
- The packet is always forwarded regardless of the result.

**Undefined**
- No accumulator is built.
- len_err_cnt is constant 0.

## Test plan
- **Back-to-back packets:** reset, sched_en = 1, header (6969, 64, ifg = 0), 8-beat packet with m_tready = 1 → m beats identical to s; pkt_cnt = 1; the second packet's first beat is exactly 3 cycles after the first tlast.
- **Gap rounding:** ifg = 100 ns → ifg_cyc = 16; next first beat at t + 18. ifg = 64 ns → ifg_cyc = 10, first beat at t + 12.
- **Bad magic:** magic 16'h1234 with a 4-beat packet → no m_tvalid; s_tready = 1 for all 4 beats; drop_cnt = 1; next good packet passes normally.
- **Backpressure and disable:** m_tready toggles 1/0 each cycle during SEND → no beat lost or duplicated. sched_en = 0 → hdr_ready = 0 with a header pending; raising sched_en → accepted the next cycle.
- **Length check (macro defined):** orig_len = 60, 8 beats with the last tstrb = 8'h0F → 60 bytes, len_err_cnt = 0. orig_len = 64 with the same packet → len_err_cnt = 1. Same packet without the macro → len_err_cnt = 0.
- **Reset mid-packet:** rst_n low after 3 of 8 beats → m_tvalid = 0 and counters = 0 in the same cycle; after release, hdr_ready = 1 and a fresh packet is sent without delay (idle_cnt saturated).
